// File: rtl/intdiv_pkg.sv
// intdiv_pkg: shared encodings for the integer divider family
package intdiv_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;
  localparam logic [1:0] SD2_ZERO = 2'b00;
  localparam logic [1:0] SD2_POS = 2'b01;
  localparam logic [1:0] SD2_NEG = 2'b11;
endpackage

// File: rtl/intdiv_booth_step.sv
// intdiv_booth_step: one radix-2 Booth add/subtract on the accumulator before the shift
module intdiv_booth_step
  import intdiv_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N:0]   acc,
  input  logic [N-1:0] z,
  input  logic [1:0]   pair,
  output logic [N:0]   sum
);
  logic [N:0] z_ext;
  always_comb begin
    z_ext = {z[N-1], z};
    sum = pair == BOOTH_ADD ? acc + z_ext : pair == BOOTH_SUB ? acc - z_ext : acc;
  end
endmodule

// File: rtl/intdiv_remul.sv
// intdiv_remul: sequential Booth reconstruction x = z*y + r with overflow and remainder-legality flags
module intdiv_remul
  import intdiv_pkg::*;
#(
  parameter int N = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   z,
  input  logic [N-1:0]   y,
  input  logic [N-1:0]   r,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] x_full,
  output logic [N-1:0]   x,
  output logic           ovf,
  output logic           rem_ok
);
  localparam int CW = $clog2(N + 1);
  state_t state, state_nx;
  logic [N:0] acc, sum, r_ext, y_ext, r_mag, y_mag;
  logic [N-1:0] q, zr, yr, rr;
  logic qm1;
  logic [CW-1:0] cnt;
  logic [2*N-1:0] xs;
  intdiv_booth_step #(.N(N)) u_step (.acc(acc), .z(zr), .pair({q[0], qm1}), .sum(sum));
  always_comb begin
    state_nx = state == IDLE ? (in_valid ? MUL : IDLE)
             : state == MUL  ? (cnt == CW'(N - 1) ? FIX : MUL)
             : state == FIX  ? DONE
             : (out_ready ? IDLE : DONE);
    in_ready = state == IDLE;
    out_valid = state == DONE;
    x = x_full[N-1:0];
    // {acc, q} is a 2N+1-bit product that always fits in 2N bits
    xs = {acc[N-1:0], q} + {{N{rr[N-1]}}, rr};
    r_ext = {rr[N-1], rr};
    y_ext = {yr[N-1], yr};
    r_mag = r_ext[N] ? -r_ext : r_ext;
    y_mag = y_ext[N] ? -y_ext : y_ext;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      q <= '0;
      qm1 <= 1'b0;
      cnt <= '0;
      zr <= '0;
      yr <= '0;
      rr <= '0;
      x_full <= '0;
      ovf <= 1'b0;
      rem_ok <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      zr <= z;
      yr <= y;
      rr <= r;
      q <= y;
      qm1 <= 1'b0;
      acc <= '0;
      cnt <= '0;
    end else if (state == MUL) begin
      {acc, q, qm1} <= {sum[N], sum, q};
      cnt <= cnt + CW'(1);
    end else if (state == FIX) begin
      x_full <= xs;
      ovf <= !(&xs[2*N-1:N-1]) && |xs[2*N-1:N-1];
      rem_ok <= yr != '0 && r_mag < y_mag && (rr == '0 || rr[N-1] == xs[2*N-1]);
    end
endmodule
